// File: rtl/dcache_pkg.sv
// dcache_pkg: refill FSM states and line geometry shared by the L1 data cache and its miss handler
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} refill_state_t;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int LINE_BYTES = WORDS_PER_LINE * 4;
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & ~32'(LINE_BYTES - 1);
  endfunction
endpackage

// File: rtl/dcache_refill_ctrl_beat_counter.sv
// line_beat_counter: loadable wrapping word index plus a beat tally that flags the last beat of a line
module line_beat_counter #(
  parameter int WORDS_PER_LINE = 4,
  localparam int OFF_W = $clog2(WORDS_PER_LINE)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [OFF_W-1:0] start,
  input  logic             adv,
  output logic [OFF_W-1:0] cnt,
  output logic             last
);
  logic [OFF_W-1:0] tally;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      cnt   <= '0;
      tally <= '0;
    end else if (load) begin
      cnt   <= start;
      tally <= '0;
    end else if (adv) begin
      cnt   <= cnt + 1'b1;
      tally <= tally + 1'b1;
    end
  assign last = &tally;
endmodule

// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl: L1 miss handler -- dirty victim write-back then line refill, one word per beat.
// Optional CRITICAL_WORD_FIRST_EN: refill starts at the missing word and wraps around the line.
module dcache_refill_ctrl #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W = 32,
  localparam int OFF_W = $clog2(WORDS_PER_LINE)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              MISS_REQ,
  input  logic [ADDR_W-1:0] MISS_ADDR,
  input  logic              VICTIM_DIRTY,
  input  logic [ADDR_W-1:0] VICTIM_ADDR,
  input  logic [31:0]       VICTIM_DATA,
  output logic [OFF_W-1:0]  VICTIM_IDX,
  output logic              LINE_INV,
  output logic              FILL_WE,
  output logic [OFF_W-1:0]  FILL_IDX,
  output logic [31:0]       FILL_DATA,
  output logic              FILL_DONE,
  output logic              STALL,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA,
  input  logic              MEM_ACK
);
  import dcache_pkg::*;
  refill_state_t state, state_nx;
  logic [ADDR_W-OFF_W-3:0] miss_line, victim_line;
  logic [OFF_W-1:0] cnt, start, fill_start;
  logic last, load, adv, unused_ok;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state       <= IDLE;
      miss_line   <= '0;
      victim_line <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && MISS_REQ) begin
        miss_line   <= MISS_ADDR[ADDR_W-1:OFF_W+2];
        victim_line <= VICTIM_ADDR[ADDR_W-1:OFF_W+2];
      end
    end
`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0] crit_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) crit_q <= '0;
    else if (state == IDLE && MISS_REQ) crit_q <= MISS_ADDR[OFF_W+1:2];
  assign fill_start = state == IDLE ? MISS_ADDR[OFF_W+1:2] : crit_q;
`else
  assign fill_start = '0;
`endif
  assign unused_ok = ^{MISS_ADDR[OFF_W+1:0], VICTIM_ADDR[OFF_W+1:0]};
  assign STALL = MISS_REQ || state != IDLE;
  always_comb begin
    state_nx  = state;
    MEM_REQ   = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    VICTIM_IDX = '0;
    FILL_WE   = 1'b0;
    FILL_IDX  = '0;
    FILL_DATA = '0;
    LINE_INV  = 1'b0;
    FILL_DONE = 1'b0;
    load      = 1'b0;
    adv       = 1'b0;
    start     = fill_start;
    case (state)
      IDLE: begin
        LINE_INV = MISS_REQ;
        load     = MISS_REQ;
        start    = VICTIM_DIRTY ? '0 : fill_start;
        if (MISS_REQ) state_nx = VICTIM_DIRTY ? WB : FILL;
      end
      WB: begin
        MEM_REQ    = 1'b1;
        MEM_WE     = 1'b1;
        MEM_ADDR   = {victim_line, cnt, 2'b00};
        MEM_WDATA  = VICTIM_DATA;
        VICTIM_IDX = cnt;
        adv        = MEM_ACK;
        load       = MEM_ACK && last;
        if (MEM_ACK && last) state_nx = FILL;
      end
      FILL: begin
        MEM_REQ   = 1'b1;
        MEM_ADDR  = {miss_line, cnt, 2'b00};
        FILL_WE   = MEM_ACK;
        FILL_IDX  = cnt;
        FILL_DATA = MEM_RDATA;
        adv       = MEM_ACK;
        if (MEM_ACK && last) state_nx = DONE;
      end
      DONE: begin
        FILL_DONE = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  line_beat_counter #(.WORDS_PER_LINE(WORDS_PER_LINE)) u_cnt (
    .CLK(CLK), .RST_N(RST_N), .load(load), .start(start), .adv(adv), .cnt(cnt), .last(last)
  );
endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// tb_dcache_refill_ctrl: directed and randomized misses against a beat-list model of the refill protocol
module tb_dcache_refill_ctrl;
  localparam int N = 4;
  typedef struct {bit we; logic [31:0] addr; int idx;} beat_t;
  logic CLK = 0, RST_N = 0, MISS_REQ = 0, VICTIM_DIRTY = 0, MEM_ACK = 0;
  logic [31:0] MISS_ADDR = 0, VICTIM_ADDR = 0, MEM_RDATA = 0, VICTIM_DATA;
  logic [1:0] VICTIM_IDX, FILL_IDX;
  logic LINE_INV, FILL_WE, FILL_DONE, STALL, MEM_REQ, MEM_WE;
  logic [31:0] FILL_DATA, MEM_ADDR, MEM_WDATA;
  logic [31:0] vline [N];
  int total = 0, bad = 0;

  dcache_refill_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .MISS_REQ(MISS_REQ), .MISS_ADDR(MISS_ADDR),
    .VICTIM_DIRTY(VICTIM_DIRTY), .VICTIM_ADDR(VICTIM_ADDR), .VICTIM_DATA(VICTIM_DATA),
    .VICTIM_IDX(VICTIM_IDX), .LINE_INV(LINE_INV), .FILL_WE(FILL_WE), .FILL_IDX(FILL_IDX),
    .FILL_DATA(FILL_DATA), .FILL_DONE(FILL_DONE), .STALL(STALL), .MEM_REQ(MEM_REQ),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .MEM_ACK(MEM_ACK)
  );

  always #5 CLK = ~CLK;
  always_comb VICTIM_DATA = vline[VICTIM_IDX];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"}, MEM_REQ, 0);
    chk({tag, "_we"}, MEM_WE, 0);
    chk({tag, "_addr"}, MEM_ADDR, 0);
    chk({tag, "_wdata"}, MEM_WDATA, 0);
    chk({tag, "_vidx"}, VICTIM_IDX, 0);
    chk({tag, "_fidx"}, FILL_IDX, 0);
    chk({tag, "_fwe"}, FILL_WE, 0);
    chk({tag, "_fdata"}, FILL_DATA, 0);
    chk({tag, "_inv"}, LINE_INV, 0);
    chk({tag, "_done"}, FILL_DONE, 0);
    chk({tag, "_stall"}, STALL, 0);
  endtask

  // One miss from acceptance to the idle cycle after FILL_DONE; optionally reset at beat abort_at.
  task automatic run_miss(input logic [31:0] ma, input logic [31:0] va, input bit dirty,
                          input int max_stall, input int abort_at, input int fb, input int fn);
    beat_t q[$];
    beat_t b;
    int st, w;
    logic [31:0] mask;
    mask = 32'(N * 4 - 1);
    for (int i = 0; i < N; i++) vline[i] = $urandom;
    if (dirty)
      for (int i = 0; i < N; i++) q.push_back('{1'b1, (va & ~mask) + 32'(4 * i), i});
    st = 0;
`ifdef CRITICAL_WORD_FIRST_EN
    st = int'((ma >> 2) % 32'(N));
`endif
    for (int i = 0; i < N; i++) begin
      w = (st + i) % N;
      q.push_back('{1'b0, (ma & ~mask) + 32'(4 * w), w});
    end
    MISS_REQ = 1; MISS_ADDR = ma; VICTIM_ADDR = va; VICTIM_DIRTY = dirty;
    MEM_ACK = 1'($urandom); MEM_RDATA = $urandom;
    #1;
    chk("accept_stall", STALL, 1);
    chk("accept_inv", LINE_INV, 1);
    chk("accept_req", MEM_REQ, 0);
    chk("accept_fwe", FILL_WE, 0);
    tick;
    MISS_ADDR = $urandom; VICTIM_ADDR = $urandom; VICTIM_DIRTY = 1'($urandom);
    foreach (q[k]) begin
      b = q[k];
      if (k == abort_at) begin
        RST_N = 0; MISS_REQ = 0; MEM_ACK = 1;
        #1;
        check_zero("abort");
        tick;
        RST_N = 1;
        tick;
        return;
      end
      repeat (k == fb ? fn : $urandom_range(0, max_stall)) begin
        MEM_ACK = 0; MEM_RDATA = $urandom;
        #1;
        chk("bp_req", MEM_REQ, 1);
        chk("bp_addr", MEM_ADDR, b.addr);
        chk("bp_we", MEM_WE, 32'(b.we));
        chk("bp_fwe", FILL_WE, 0);
        chk("bp_stall", STALL, 1);
        tick;
      end
      MEM_ACK = 1; MEM_RDATA = $urandom;
      #1;
      chk("beat_req", MEM_REQ, 1);
      chk("beat_addr", MEM_ADDR, b.addr);
      chk("beat_we", MEM_WE, 32'(b.we));
      chk("beat_fwe", FILL_WE, 32'(!b.we));
      chk("beat_inv", LINE_INV, 0);
      chk("beat_done", FILL_DONE, 0);
      if (b.we) begin
        chk("wb_idx", VICTIM_IDX, b.idx);
        chk("wb_data", MEM_WDATA, vline[b.idx]);
      end else begin
        chk("fill_idx", FILL_IDX, b.idx);
        chk("fill_data", FILL_DATA, MEM_RDATA);
      end
      tick;
    end
    MEM_ACK = 1'($urandom);
    #1;
    chk("done_pulse", FILL_DONE, 1);
    chk("done_req", MEM_REQ, 0);
    chk("done_stall", STALL, 1);
    chk("done_fwe", FILL_WE, 0);
    MISS_REQ = 0;
    tick;
    chk("post_done", FILL_DONE, 0);
    chk("post_stall", STALL, 0);
    chk("post_req", MEM_REQ, 0);
  endtask

  initial begin
    #2;
    check_zero("reset");
    tick;
    tick;
    RST_N = 1;
    tick;
    // Stray ACK while idle must do nothing.
    MEM_ACK = 1; MEM_RDATA = 32'hDEAD_BEEF;
    repeat (3) begin
      #1;
      chk("idle_ack_fwe", FILL_WE, 0);
      chk("idle_ack_stall", STALL, 0);
      chk("idle_ack_req", MEM_REQ, 0);
      chk("idle_ack_done", FILL_DONE, 0);
      tick;
    end
    run_miss(32'h0000_1234, 32'h0000_0040, 1'b0, 0, -1, -1, 0);
    run_miss(32'h0000_1234, 32'h0000_0040, 1'b1, 0, -1, -1, 0);
    run_miss(32'h0000_1234, 32'h0000_0040, 1'b0, 0, -1, 2, 3);
    run_miss(32'h0000_1234, 32'h0000_0040, 1'b0, 0, 2, -1, 0);
    run_miss(32'h0000_1234, 32'h0000_0040, 1'b0, 0, -1, -1, 0);
    run_miss(32'h0000_1238, 32'h0000_0040, 1'b0, 0, -1, -1, 0);
    run_miss(32'h0000_1238, 32'h0000_0080, 1'b1, 1, -1, -1, 0);
    repeat (25) run_miss($urandom, $urandom, 1'($urandom), 2, -1, -1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
